icache_sa: RTL
==============

Name: icache_sa

Overview:
- Parametrised set-associative instruction cache; successor to the direct-mapped, single-word, externally filled icache.
- Sits between the IF unit and the memory controller.
- Hits are answered combinationally in the query cycle. Misses are refilled by an internal FSM that fetches a whole multi-word line, installs it into a round-robin victim way, and returns the requested word.
- Supports whole-cache invalidate (fence.i).

Parameters:
ADDR_WIDTH, 32, byte address width
INST_WIDTH, 32, instruction word width
WAYS, 2, associativity (power of 2, >=1)
SETS, 64, number of sets (power of 2)
LINE_WORDS, 4, instruction words per line (power of 2, >=2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
query_valid  in  1  IF requests instruction at query_pc
query_pc  in  ADDR_WIDTH  word-aligned fetch address
hit  out  1  query_pc present this cycle (combinational)
out_valid  out  1  returned_inst valid (hit, or refill response)
returned_inst  out  INST_WIDTH  instruction for query_pc
busy  out  1  refill in progress; IF must hold query_pc stable
flush  in  1  invalidate all lines
mem_req  out  1  word read request to memory controller
mem_addr  out  ADDR_WIDTH  word address of request
mem_ack  in  1  mem_data valid; completes current request
mem_data  in  INST_WIDTH  returned word

Behaviour:
- Address split: offset = pc[1:0] (ignored); word = next log2(LINE_WORDS) bits; index = next log2(SETS) bits; tag = remaining upper bits.
- Reset (rst low, async): all valid bits 0, victim pointers 0, FSM IDLE, mem_req 0, mem_addr 0, out_valid 0, busy 0, returned_inst 0. Tag and data arrays are not reset.
- Hit: in IDLE, query_valid with a valid way whose tag matches -> hit=1, out_valid=1, returned_inst = that way's word, same cycle. Zero latency. No state change.
- Miss: in IDLE, query_valid and no match -> latch pc, clear counter k, go FILL. out_valid=0.
- FILL:
  - busy=1; mem_req=1; mem_addr = line base + 4*k.
  - On mem_ack, write mem_data into line buffer[k] and increment k.
  - Only one request is outstanding. mem_req stays high until the ack for word LINE_WORDS-1 arrives.
- INSTALL (1 cycle):
  - Write line buffer, tag and valid=1 into way victim_ptr[index].
  - victim_ptr[index] increments, wrapping at WAYS.
  - If any way of the set is invalid, choose the lowest-numbered invalid way instead and leave the pointer unchanged.
- RESP (1 cycle): out_valid=1, returned_inst = buffer[word of latched pc], hit=0, busy=0. Then go IDLE.
- Total miss latency: LINE_WORDS acks + 2 cycles.
- Queries while busy are ignored, including any hit lookup (hit=0, out_valid=0).
- Flush:
  - Clears every valid bit at the next edge.
  - In the flush cycle hit and out_valid are forced 0.
  - Flush during FILL sets an abort flag. The FSM keeps mem_req until the current word is acked, then returns to IDLE with no INSTALL and no RESP.
  - Flush in INSTALL cancels the install. Flush in RESP still delivers the word but nothing is installed.
- mem_ack while not in FILL is ignored.
- Counter k wraps only through FSM exit; k never exceeds LINE_WORDS-1.
- Asserting rst mid-refill aborts immediately: mem_req drops asynchronously.
- Widths: index/word/tag widths derived via $clog2. The tag compare uses the full tag field.

Decomposition:
- Shared package (defines): address and instruction types, TRUE/FALSE, ZERO_WORD, FSM state encodings (IDLE, FILL, INSTALL, RESP).
- One natural sub-module: icache_way. One tag/valid/data array per way, with a lookup port (index, tag -> match, word) and an install port. Instantiated WAYS times via generate.
- Victim selection, line buffer and FSM live in icache_sa.

Test Plan:
- Cold miss: reset, query pc=0x1008 with mem acking 1 cycle after each req (data = addr^0xA5A5A5A5) -> mem_addr 0x1000,0x1004,0x1008,0x100C; RESP returned_inst=0xA5A5B5AD; a following query of 0x100C hits in 0 cycles.
- Conflict/associativity (WAYS=2,SETS=64,LINE_WORDS=4): fill lines 0x0000, 0x0400 and 0x0800, all at index 0 -> third fill evicts way0 (0x0000); 0x0400 still hits, 0x0000 misses.
- Round-robin: after the previous case, miss on 0x0000 -> evicts way1 (0x0400); victim_ptr[0] returns to 0.
- Flush: hit on 0x1008, assert flush 1 cycle -> hit=0 in flush cycle; the next query of 0x1008 misses and issues mem_req to 0x1000.
- Flush mid-fill: flush after 2nd ack -> mem_req held until 3rd ack, then IDLE, no out_valid; a re-query of the same pc misses.
- Async reset mid-fill: drive rst low between clock edges in FILL -> mem_req and busy drop at once; after release every prior line misses.

Source files
------------

// File: rtl/icache_sa_pkg.sv
// Shared types and constants for the set-associative instruction cache.
package icache_sa_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned INST_W = 32;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [INST_W-1:0] inst_t;

    localparam logic  TRUE      = 1'b1;
    localparam logic  FALSE     = 1'b0;
    localparam inst_t ZERO_WORD = '0;

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StInstall,
        StResp
    } state_e;

endpackage

// File: rtl/icache_way.sv
// One cache way: valid bits, tag array and line data array with a lookup and an install port.
module icache_way
    import icache_sa_pkg::*;
#(
    parameter int unsigned SETS       = 64,
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned INST_WIDTH = 32,
    parameter int unsigned TAG_W      = 22,
    localparam int unsigned IDX_W     = $clog2(SETS),
    localparam int unsigned WORD_W    = $clog2(LINE_WORDS)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   flush,
    input  logic [IDX_W-1:0]                       rd_index,
    input  logic [TAG_W-1:0]                       rd_tag,
    input  logic [WORD_W-1:0]                      rd_word,
    output logic                                   match,
    output logic [INST_WIDTH-1:0]                  rd_data,
    input  logic [IDX_W-1:0]                       wr_index,
    output logic                                   wr_valid,
    input  logic                                   wr_en,
    input  logic [TAG_W-1:0]                       wr_tag,
    input  logic [LINE_WORDS-1:0][INST_WIDTH-1:0]  wr_line
);

    logic [SETS-1:0]                      valid_q;
    logic [TAG_W-1:0]                     tag_q  [SETS];
    logic [LINE_WORDS-1:0][INST_WIDTH-1:0] data_q [SETS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_index] <= TRUE;
        end
    end

    // Tag and data storage is deliberately left unreset; valid bits gate every use.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_index]  <= wr_tag;
            data_q[wr_index] <= wr_line;
        end
    end

    assign match    = valid_q[rd_index] && (tag_q[rd_index] == rd_tag);
    assign rd_data  = data_q[rd_index][rd_word];
    assign wr_valid = valid_q[wr_index];

endmodule

// File: rtl/icache_sa.sv
// Set-associative instruction cache with line refill FSM and round-robin replacement.
module icache_sa
    import icache_sa_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_W,
    parameter int unsigned INST_WIDTH = INST_W,
    parameter int unsigned WAYS       = 2,
    parameter int unsigned SETS       = 64,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  query_valid,
    input  logic [ADDR_WIDTH-1:0] query_pc,
    output logic                  hit,
    output logic                  out_valid,
    output logic [INST_WIDTH-1:0] returned_inst,
    output logic                  busy,
    input  logic                  flush,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [INST_WIDTH-1:0] mem_data
);

    localparam int unsigned WORD_W  = $clog2(LINE_WORDS);
    localparam int unsigned IDX_W   = $clog2(SETS);
    localparam int unsigned IDX_LSB = 2 + WORD_W;
    localparam int unsigned TAG_LSB = IDX_LSB + IDX_W;
    localparam int unsigned TAG_W   = ADDR_WIDTH - TAG_LSB;
    localparam int unsigned WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1;

    state_e                                state_q, state_d;
    logic [ADDR_WIDTH-1:2]                 pc_q, pc_d;
    logic [WORD_W-1:0]                     k_q, k_d;
    logic                                  abort_q, abort_d;
    logic [LINE_WORDS-1:0][INST_WIDTH-1:0] line_q, line_d;
    logic [WAY_W-1:0]                      victim_q [SETS];

    logic [1:0]                     unused_offset;
    logic [WAYS-1:0]                way_match;
    logic [WAYS-1:0]                way_wr_valid;
    logic [WAYS-1:0][INST_WIDTH-1:0] way_rdata;
    logic [INST_WIDTH-1:0]          hit_word;
    logic                           hit_any;
    logic                           lookup_ok;
    logic                           install_en;
    logic                           set_full;
    logic [WAY_W-1:0]               victim;

    wire [WORD_W-1:0] q_word  = query_pc[IDX_LSB-1:2];
    wire [IDX_W-1:0]  q_index = query_pc[TAG_LSB-1:IDX_LSB];
    wire [TAG_W-1:0]  q_tag   = query_pc[ADDR_WIDTH-1:TAG_LSB];
    wire [WORD_W-1:0] l_word  = pc_q[IDX_LSB-1:2];
    wire [IDX_W-1:0]  l_index = pc_q[TAG_LSB-1:IDX_LSB];
    wire [TAG_W-1:0]  l_tag   = pc_q[ADDR_WIDTH-1:TAG_LSB];

    assign unused_offset = query_pc[1:0];
    assign lookup_ok     = (state_q == StIdle) && query_valid && !flush;
    assign install_en    = (state_q == StInstall) && !flush;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        icache_way #(
            .SETS       (SETS),
            .LINE_WORDS (LINE_WORDS),
            .INST_WIDTH (INST_WIDTH),
            .TAG_W      (TAG_W)
        ) u_way (
            .clk      (clk),
            .rst      (rst),
            .flush    (flush),
            .rd_index (q_index),
            .rd_tag   (q_tag),
            .rd_word  (q_word),
            .match    (way_match[w]),
            .rd_data  (way_rdata[w]),
            .wr_index (l_index),
            .wr_valid (way_wr_valid[w]),
            .wr_en    (install_en && (victim == WAY_W'(w))),
            .wr_tag   (l_tag),
            .wr_line  (line_q)
        );
    end

    always_comb begin
        hit_word = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (way_match[w]) hit_word = way_rdata[w];
        end
    end
    assign hit_any = |way_match;

    // Lowest invalid way wins; the round-robin pointer only matters for a full set.
    always_comb begin
        victim   = victim_q[l_index];
        set_full = TRUE;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!way_wr_valid[w]) begin
                victim   = WAY_W'(w);
                set_full = FALSE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < SETS; s++) victim_q[s] <= '0;
        end else if (install_en && set_full) begin
            victim_q[l_index] <= (victim_q[l_index] == WAY_W'(WAYS - 1)) ? '0
                                                                         : victim_q[l_index] + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            pc_q    <= '0;
            k_q     <= '0;
            abort_q <= FALSE;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            k_q     <= k_d;
            abort_q <= abort_d;
            line_q  <= line_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        k_d           = k_q;
        abort_d       = abort_q;
        line_d        = line_q;
        hit           = FALSE;
        out_valid     = FALSE;
        returned_inst = INST_WIDTH'(ZERO_WORD);
        busy          = FALSE;
        mem_req       = FALSE;
        mem_addr      = '0;
        unique case (state_q)
            StIdle: begin
                if (lookup_ok) begin
                    if (hit_any) begin
                        hit           = TRUE;
                        out_valid     = TRUE;
                        returned_inst = hit_word;
                    end else begin
                        pc_d    = query_pc[ADDR_WIDTH-1:2];
                        k_d     = '0;
                        abort_d = FALSE;
                        state_d = StFill;
                    end
                end
            end
            StFill: begin
                busy     = TRUE;
                mem_req  = TRUE;
                mem_addr = {pc_q[ADDR_WIDTH-1:IDX_LSB], k_q, 2'b00};
                if (flush) abort_d = TRUE;
                if (mem_ack) begin
                    line_d[k_q] = mem_data;
                    // An aborted fill drains only the outstanding word, then drops the line.
                    if (abort_q || flush) begin
                        k_d     = '0;
                        state_d = StIdle;
                    end else if (k_q == WORD_W'(LINE_WORDS - 1)) begin
                        k_d     = '0;
                        state_d = StInstall;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            StInstall: begin
                busy    = TRUE;
                state_d = StResp;
            end
            StResp: begin
                out_valid     = TRUE;
                returned_inst = line_q[l_word];
                state_d       = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule
